// File: rtl/seg_pkg.sv
//------------------------------------------------------------------------------
// seg_pkg : BCD / seven-segment constants and decode shared with the display driver
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;

  // Segment bit order {g,f,e,d,c,b,a}, active high
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [BCD_W-1:0] digit);
    logic [SEG_W-1:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_updown.sv
//------------------------------------------------------------------------------
// bcd_digit_updown : single BCD digit with inc/dec, load and clear
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_digit_updown
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             inc,
  input  logic             dec,
  output logic [BCD_W-1:0] q,
  output logic             carry,
  output logic             borrow
);

  // Carry/borrow are combinational so the ripple completes within one edge
  assign carry  = inc && (q == 4'd9);
  assign borrow = dec && (q == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (inc) begin
      q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
    end else if (dec) begin
      q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/updown_bcd_display_counter.sv
//------------------------------------------------------------------------------
// updown_bcd_display_counter : 4-digit BCD up/down counter with registered 7-seg outputs
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module updown_bcd_display_counter
  import seg_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 up,
  input  logic                 clear,
  input  logic                 load,
  input  logic [4*BCD_W-1:0]   load_val,
  output logic [4*BCD_W-1:0]   count,
  output logic                 wrap,
  output logic [SEG_W-1:0]     a,
  output logic [SEG_W-1:0]     b,
  output logic [SEG_W-1:0]     c,
  output logic [SEG_W-1:0]     d
);

  localparam int P_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [P_W-1:0] P_MAX = P_W'(TICK_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_LEAD_RST = BLANK_LZ ? SEG_BLANK : SEG_0;

  logic [P_W-1:0]     p;
  logic               tick;
  logic [3:0]         inc_in;
  logic [3:0]         dec_in;
  logic [3:0]         carry;
  logic [3:0]         borrow;
  logic [4*BCD_W-1:0] ld_clean;

  assign tick = en && (p == P_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p <= '0;
    end else if (clear || load) begin
      p <= '0;
    end else if (en) begin
      p <= tick ? '0 : p + 1'b1;
    end
  end

  assign inc_in = {carry[2:0], tick && up};
  assign dec_in = {borrow[2:0], tick && !up};

  generate
    for (genvar i = 0; i < 4; i++) begin : g_digit
      // Non-BCD load digits are stored as zero
      assign ld_clean[BCD_W*i +: BCD_W] =
        (load_val[BCD_W*i +: BCD_W] > 4'd9) ? 4'd0 : load_val[BCD_W*i +: BCD_W];

      bcd_digit_updown u_digit (
        .clk    (clk),
        .reset  (reset),
        .clr    (clear),
        .ld     (load),
        .ld_val (ld_clean[BCD_W*i +: BCD_W]),
        .inc    (inc_in[i]),
        .dec    (dec_in[i]),
        .q      (count[BCD_W*i +: BCD_W]),
        .carry  (carry[i]),
        .borrow (borrow[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= !clear && !load && (carry[3] || borrow[3]);
    end
  end

  logic blank_a;
  logic blank_b;
  logic blank_c;

  always_comb begin
    blank_a = BLANK_LZ && (count[15:12] == 4'd0);
    blank_b = blank_a && (count[11:8] == 4'd0);
    blank_c = blank_b && (count[7:4] == 4'd0);
  end

  // Segments follow the registered count by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a <= SEG_LEAD_RST;
      b <= SEG_LEAD_RST;
      c <= SEG_LEAD_RST;
      d <= SEG_0;
    end else begin
      a <= blank_a ? SEG_BLANK : bcd_to_seg(count[15:12]);
      b <= blank_b ? SEG_BLANK : bcd_to_seg(count[11:8]);
      c <= blank_c ? SEG_BLANK : bcd_to_seg(count[7:4]);
      d <= bcd_to_seg(count[3:0]);
    end
  end

endmodule

`default_nettype wire
